// File: rtl/ei_axi4_pkg.sv
// Shared AXI4 write-path types: burst/response encodings, AW queue entry, response ranking.
// Latency: none (types and a pure function only).
// Backpressure: not applicable.
package ei_axi4_pkg;

   typedef enum logic [1:0] {
      FIXED = 2'b00,
      INCR  = 2'b01,
      WRAP  = 2'b10
   } burst_type_e;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } response_e;

   // Burst attributes of an AW queue entry; the full entry is {id, addr, aw_attr_t}
   // because id/addr widths are parameters of the instantiating module.
   typedef struct packed {
      logic [7:0]  len;
      logic [2:0]  size;
      burst_type_e burst;
   } aw_attr_t;

   // Encodings are ordered by severity, so the numerically larger one wins.
   function automatic response_e resp_worst(input response_e a, input response_e b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/ei_axi4_sync_fifo.sv
// Generic synchronous FIFO with occupancy count, used for the AW and B queues.
// Latency: a pushed entry is visible at the head the cycle after the push edge.
// Backpressure: push is ignored when full, pop is ignored when empty; simultaneous push/pop both honoured.
module ei_axi4_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             aclk,
   input  logic             aresetn,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_dat,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] cnt
);

   logic [WIDTH-1:0] store_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign full    = (cnt_q == CNT_W'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign cnt     = cnt_q;
   assign pop_dat = store_q[rd_ptr_q];

   // Next pointer/count values from the qualified push and pop strobes
   always_comb begin
      do_push  = push && !full;
      do_pop   = pop && !empty;
      wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
      rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
      cnt_d    = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
   end

   // Pointer and count registers, cleared by synchronous reset
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Entry storage; stale contents are harmless because empty gates every read
   always_ff @(posedge aclk) begin
      if (do_push) begin
         store_q[wr_ptr_q] <= push_dat;
      end
   end

endmodule

// File: rtl/ei_axi4_slave_write_responder.sv
// AXI4 slave write responder: queues AW bursts, writes strobed W beats to word memory, returns in-order B.
// Latency: first W beat one cycle after AW acceptance; B valid the cycle after the final W beat.
// Backpressure: awready drops when the AW queue is full; wready drops when the B queue is full.
// Optional error reporting (SLVERR/DECERR) is enabled by defining EI_AXI4_SLV_ERR_EN.
module ei_axi4_slave_write_responder
   import ei_axi4_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int ID_WIDTH    = 4,
   parameter int OUTSTANDING = 4,
   parameter int MEM_DEPTH   = 1024
) (
   input  logic                    aclk,
   input  logic                    aresetn,
   input  logic [ID_WIDTH-1:0]     awid,
   input  logic [ADDR_WIDTH-1:0]   awaddr,
   input  logic [7:0]              awlen,
   input  logic [2:0]              awsize,
   input  burst_type_e             awburst,
   input  logic                    awvalid,
   output logic                    awready,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [DATA_WIDTH/8-1:0] wstrb,
   input  logic                    wlast,
   input  logic                    wvalid,
   output logic                    wready,
   output logic [ID_WIDTH-1:0]     bid,
   output response_e               bresp,
   output logic                    bvalid,
   input  logic                    bready
);

   localparam int         STRB_W   = DATA_WIDTH / 8;
   localparam int         LSB      = $clog2(STRB_W);
   localparam logic [2:0] MAX_SIZE = 3'(LSB);
   localparam int         MEM_AW   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam int         CNT_W    = $clog2(OUTSTANDING) + 1;
   localparam int         AW_W     = ID_WIDTH + ADDR_WIDTH + $bits(aw_attr_t);
   localparam int         B_W      = ID_WIDTH + 2;

   typedef enum logic {W_IDLE, W_DATA} w_state_e;

   // Registered state
   w_state_e              state_q, state_d;
   logic [7:0]            beat_cnt_q, beat_cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   response_e             err_q, err_d;
   logic                  aw_rdy_q, aw_rdy_d;
   logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

   // AW queue
   logic                  aw_push, aw_pop, aw_full, aw_empty;
   logic [CNT_W-1:0]      aw_cnt;
   logic [AW_W-1:0]       aw_push_dat, aw_pop_dat;
   aw_attr_t              aw_in_attr;
   logic [ID_WIDTH-1:0]   head_id;
   logic [ADDR_WIDTH-1:0] head_addr;
   aw_attr_t              head_attr;

   // B queue
   logic                  b_push, b_full, b_empty;
   logic [B_W-1:0]        b_push_dat, b_pop_dat;
   logic [CNT_W-1:0]      b_cnt_unused;
   logic [ID_WIDTH-1:0]   b_head_id;
   logic [1:0]            b_head_resp;

   // Beat address generation and write qualification
   logic [2:0]            eff_size;
   logic [ADDR_WIDTH-1:0] size_bytes, beat_addr, aligned_addr, incr_addr, next_addr;
   logic [ADDR_WIDTH-1:0] wrap_span, wrap_lo, wrap_hi, word_idx;
   logic                  wrap_ok, in_range, last_beat, w_hs, write_ok, mem_we;
   logic [MEM_AW-1:0]     mem_idx;
   response_e             beat_resp, acc_resp;

   assign awready = aw_rdy_q && !aw_full;
   assign aw_push = awvalid && awready;
   assign wready  = (state_q == W_DATA) && !b_full;
   assign w_hs    = wvalid && wready;

   assign {head_id, head_addr, head_attr} = aw_pop_dat;
   assign {b_head_id, b_head_resp}        = b_pop_dat;

   assign bvalid = !b_empty;
   assign bid    = bvalid ? b_head_id : '0;
   assign bresp  = bvalid ? response_e'(b_head_resp) : OKAY;

   // Pack the incoming AW fields into a queue entry
   always_comb begin
      aw_in_attr.len   = awlen;
      aw_in_attr.size  = awsize;
      aw_in_attr.burst = awburst;
      aw_push_dat      = {awid, awaddr, aw_in_attr};
   end

   ei_axi4_sync_fifo #(
      .WIDTH (AW_W),
      .DEPTH (OUTSTANDING)
   ) u_aw_q (
      .aclk     (aclk),
      .aresetn  (aresetn),
      .push     (aw_push),
      .push_dat (aw_push_dat),
      .pop      (aw_pop),
      .pop_dat  (aw_pop_dat),
      .full     (aw_full),
      .empty    (aw_empty),
      .cnt      (aw_cnt)
   );

   ei_axi4_sync_fifo #(
      .WIDTH (B_W),
      .DEPTH (OUTSTANDING)
   ) u_b_q (
      .aclk     (aclk),
      .aresetn  (aresetn),
      .push     (b_push),
      .push_dat (b_push_dat),
      .pop      (bvalid && bready),
      .pop_dat  (b_pop_dat),
      .full     (b_full),
      .empty    (b_empty),
      .cnt      (b_cnt_unused)
   );

   // Current beat address, next beat address and memory range decode for the head burst
   always_comb begin
      eff_size     = (head_attr.size > MAX_SIZE) ? MAX_SIZE : head_attr.size;
      size_bytes   = ADDR_WIDTH'(1) << eff_size;
      beat_addr    = (beat_cnt_q == 8'd0) ? head_addr : addr_q;
      aligned_addr = beat_addr & ~(size_bytes - ADDR_WIDTH'(1));
      incr_addr    = aligned_addr + size_bytes;
      wrap_span    = (ADDR_WIDTH'(head_attr.len) + ADDR_WIDTH'(1)) << eff_size;
      wrap_lo      = beat_addr & ~(wrap_span - ADDR_WIDTH'(1));
      wrap_hi      = wrap_lo + wrap_span;
      // WRAP with a length other than 2/4/8/16 beats degrades to INCR
      wrap_ok      = (head_attr.burst == WRAP) &&
                     ((head_attr.len == 8'd1) || (head_attr.len == 8'd3) ||
                      (head_attr.len == 8'd7) || (head_attr.len == 8'd15));
      if (head_attr.burst == FIXED) begin
         next_addr = beat_addr;
      end else if (wrap_ok && (incr_addr == wrap_hi)) begin
         next_addr = wrap_lo;
      end else begin
         next_addr = incr_addr;
      end
      word_idx  = beat_addr >> LSB;
      in_range  = (word_idx < ADDR_WIDTH'(MEM_DEPTH));
      mem_idx   = word_idx[MEM_AW-1:0];
      last_beat = (beat_cnt_q == head_attr.len);
   end

`ifdef EI_AXI4_SLV_ERR_EN
   // Per-beat error classification; DECERR is assigned last so it outranks SLVERR
   always_comb begin
      beat_resp = OKAY;
      if ((head_attr.size > MAX_SIZE) || (wlast != last_beat)) begin
         beat_resp = SLVERR;
      end
      if (!in_range) begin
         beat_resp = DECERR;
      end
      write_ok = in_range && (head_attr.size <= MAX_SIZE);
   end
`else
   logic unused_wlast;
   assign unused_wlast = wlast;

   // Without error reporting only out-of-range beats are filtered, silently
   always_comb begin
      beat_resp = OKAY;
      write_ok  = in_range;
   end
`endif

   // W-channel FSM next state, beat counter, response accumulation and queue strobes
   always_comb begin
      state_d    = state_q;
      beat_cnt_d = beat_cnt_q;
      addr_d     = addr_q;
      err_d      = err_q;
      aw_rdy_d   = 1'b1;
      aw_pop     = 1'b0;
      b_push     = 1'b0;
      acc_resp   = resp_worst((beat_cnt_q == 8'd0) ? OKAY : err_q, beat_resp);
      b_push_dat = {head_id, acc_resp};
      case (state_q)
         W_IDLE: begin
            // Entering on the push edge lets the first beat land one cycle after AW
            if (!aw_empty || aw_push) begin
               state_d = W_DATA;
            end
         end
         W_DATA: begin
            if (w_hs) begin
               addr_d = next_addr;
               err_d  = acc_resp;
               // The burst ends on its programmed length regardless of wlast
               if (last_beat) begin
                  aw_pop     = 1'b1;
                  b_push     = 1'b1;
                  beat_cnt_d = 8'd0;
                  if ((aw_cnt <= CNT_W'(1)) && !aw_push) begin
                     state_d = W_IDLE;
                  end
               end else begin
                  beat_cnt_d = beat_cnt_q + 8'd1;
               end
            end
         end
         default: state_d = W_IDLE;
      endcase
      mem_we = w_hs && write_ok && aresetn;
   end

   // FSM and burst-tracking registers; reset discards any in-flight burst
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q    <= W_IDLE;
         beat_cnt_q <= 8'd0;
         addr_q     <= '0;
         err_q      <= OKAY;
         aw_rdy_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         beat_cnt_q <= beat_cnt_d;
         addr_q     <= addr_d;
         err_q      <= err_d;
         aw_rdy_q   <= aw_rdy_d;
      end
   end

   // Byte-strobed write into the word store on the W handshake edge; not reset
   always_ff @(posedge aclk) begin
      if (mem_we) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (wstrb[b]) begin
               mem_q[mem_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_ei_axi4_slave_write_responder.sv
// Directed bench for ei_axi4_slave_write_responder: burst vector table plus hand-written
// latency, multiple-outstanding and mid-burst reset sequences.
// Expected bresp values follow EI_AXI4_SLV_ERR_EN when it is defined for the build.
module tb_ei_axi4_slave_write_responder;
   import ei_axi4_pkg::*;

`ifdef EI_AXI4_SLV_ERR_EN
   localparam response_e   EXP_DEC  = DECERR;
   localparam response_e   EXP_SLV  = SLVERR;
   localparam logic [31:0] EXP_OVSZ = 32'h0BADBEEF;
`else
   localparam response_e   EXP_DEC  = OKAY;
   localparam response_e   EXP_SLV  = OKAY;
   localparam logic [31:0] EXP_OVSZ = 32'h600DD00D;
`endif

   logic        aclk = 1'b0;
   logic        aresetn;
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   burst_type_e awburst;
   logic        awvalid, awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast, wvalid, wready;
   logic [3:0]  bid;
   response_e   bresp;
   logic        bvalid, bready;

   int n_checks = 0;
   int n_errors = 0;

   always #5 aclk = ~aclk;

   ei_axi4_slave_write_responder #(
      .DATA_WIDTH  (32),
      .ADDR_WIDTH  (32),
      .ID_WIDTH    (4),
      .OUTSTANDING (4),
      .MEM_DEPTH   (1024)
   ) dut (
      .aclk    (aclk),
      .aresetn (aresetn),
      .awid    (awid),
      .awaddr  (awaddr),
      .awlen   (awlen),
      .awsize  (awsize),
      .awburst (awburst),
      .awvalid (awvalid),
      .awready (awready),
      .wdata   (wdata),
      .wstrb   (wstrb),
      .wlast   (wlast),
      .wvalid  (wvalid),
      .wready  (wready),
      .bid     (bid),
      .bresp   (bresp),
      .bvalid  (bvalid),
      .bready  (bready)
   );

   typedef struct {
      logic [3:0]  id;
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      burst_type_e burst;
      logic [15:0] strb_pat;   // beat i uses nibble (i % 4)
      logic [31:0] data0;      // beat i carries data0 + i
      int          wlast_at;   // beat index that carries wlast
      int          w0;
      logic [31:0] v0;
      int          w1;
      logic [31:0] v1;
      response_e   resp;
   } vec_t;

   localparam int NVEC = 14;
   vec_t vecs [NVEC];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input burst_type_e burst);
      @(negedge aclk);
      awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
      awvalid = 1'b1;
      for (int t = 0; t < 64 && !awready; t++) @(negedge aclk);
      check("aw_accept", awready, 1);
      if (awready) begin
         @(posedge aclk);
         #1;
      end
      awvalid = 1'b0;
   endtask

   task automatic w_send(input logic [31:0] data, input logic [3:0] strb, input logic last);
      @(negedge aclk);
      wdata = data; wstrb = strb; wlast = last;
      wvalid = 1'b1;
      for (int t = 0; t < 64 && !wready; t++) @(negedge aclk);
      check("w_accept", wready, 1);
      if (wready) begin
         @(posedge aclk);
         #1;
      end
      wvalid = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input int k);
      aw_send(v.id, v.addr, v.len, v.size, v.burst);
      for (int i = 0; i <= int'(v.len); i++) begin
         w_send(v.data0 + 32'(i), v.strb_pat[4*(i%4) +: 4], i == v.wlast_at);
      end
      @(negedge aclk);
      for (int t = 0; t < 64 && !bvalid; t++) @(negedge aclk);
      check($sformatf("vec%0d_bvalid", k), bvalid, 1);
      if (bvalid) begin
         check($sformatf("vec%0d_bid", k), bid, v.id);
         check($sformatf("vec%0d_bresp", k), bresp, v.resp);
         @(posedge aclk);
         #1;
      end
      check($sformatf("vec%0d_mem%0d", k, v.w0), dut.mem_q[v.w0], v.v0);
      check($sformatf("vec%0d_mem%0d", k, v.w1), dut.mem_q[v.w1], v.v1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nb;
      //        id     addr        len   sz    burst  strb      data0         last w0   v0            w1   v1            resp
      vecs[0]  = '{4'd3,  32'h10,   8'd3, 3'd2, INCR,  16'hFFFF, 32'd1,        3,   4,   32'd1,        7,   32'd4,        OKAY};
      vecs[1]  = '{4'd1,  32'h38,   8'd3, 3'd2, WRAP,  16'hFFFF, 32'h100,      3,   12,  32'h102,      15,  32'h101,      OKAY};
      vecs[2]  = '{4'd2,  32'h80,   8'd0, 3'd2, INCR,  16'hFFFF, 32'hAABBCCDD, 0,   32,  32'hAABBCCDD, 32,  32'hAABBCCDD, OKAY};
      vecs[3]  = '{4'd4,  32'h80,   8'd1, 3'd2, FIXED, 16'h0081, 32'h11223344, 1,   32,  32'h11BBCC44, 32,  32'h11BBCC44, OKAY};
      vecs[4]  = '{4'd5,  32'h100,  8'd3, 3'd0, INCR,  16'h8421, 32'h03020100, 3,   64,  32'h03020100, 64,  32'h03020100, OKAY};
      vecs[5]  = '{4'd6,  32'h48,   8'd2, 3'd2, WRAP,  16'hFFFF, 32'h500,      2,   18,  32'h500,      20,  32'h502,      OKAY};
      vecs[6]  = '{4'd7,  32'h44,   8'd1, 3'd2, WRAP,  16'hFFFF, 32'h600,      1,   17,  32'h600,      16,  32'h601,      OKAY};
      vecs[7]  = '{4'd8,  32'h0,    8'd0, 3'd2, INCR,  16'hFFFF, 32'hCAFEF00D, 0,   0,   32'hCAFEF00D, 0,   32'hCAFEF00D, OKAY};
      vecs[8]  = '{4'd9,  32'h1000, 8'd0, 3'd2, INCR,  16'hFFFF, 32'hDEAD0000, 0,   0,   32'hCAFEF00D, 0,   32'hCAFEF00D, EXP_DEC};
      vecs[9]  = '{4'd10, 32'h200,  8'd3, 3'd2, INCR,  16'hFFFF, 32'h700,      1,   128, 32'h700,      131, 32'h703,      EXP_SLV};
      vecs[10] = '{4'd11, 32'h3C8,  8'd15,3'd2, WRAP,  16'hFFFF, 32'h900,      15,  240, 32'h90E,      242, 32'h900,      OKAY};
      vecs[11] = '{4'd12, 32'h2F0,  8'd7, 3'd1, INCR,  16'hC3C3, 32'h12340000, 7,   188, 32'h12340000, 191, 32'h12340006, OKAY};
      vecs[12] = '{4'd13, 32'h340,  8'd0, 3'd2, INCR,  16'hFFFF, 32'h0BADBEEF, 0,   208, 32'h0BADBEEF, 208, 32'h0BADBEEF, OKAY};
      vecs[13] = '{4'd14, 32'h340,  8'd0, 3'd3, INCR,  16'hFFFF, 32'h600DD00D, 0,   208, EXP_OVSZ,     208, EXP_OVSZ,     EXP_SLV};

      aresetn = 1'b0;
      awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = INCR; awvalid = 1'b0;
      wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
      bready = 1'b1;

      // Reset state
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      check("rst_awready", awready, 0);
      check("rst_wready", wready, 0);
      check("rst_bvalid", bvalid, 0);
      check("rst_bid", bid, 0);
      check("rst_bresp", bresp, OKAY);
      aresetn = 1'b1;
      check("awready_before_first_edge", awready, 0);
      @(negedge aclk);
      check("awready_after_release", awready, 1);

      // AW at edge N -> W at N+1 -> B valid right after the W edge
      aw_send(4'd7, 32'h60, 8'd0, 3'd2, INCR);
      @(negedge aclk);
      check("wready_after_aw", wready, 1);
      wdata = 32'h77; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
      @(posedge aclk);
      #1 wvalid = 1'b0;
      @(negedge aclk);
      check("bvalid_after_last_w", bvalid, 1);
      check("bid_after_last_w", bid, 7);
      @(posedge aclk);
      @(negedge aclk);
      check("bvalid_after_pop", bvalid, 0);
      check("lat_mem24", dut.mem_q[24], 32'h77);

      // Table of bursts
      for (int k = 0; k < NVEC; k++) begin
         run_vec(vecs[k], k);
      end

      // Four outstanding AWs with W stalled and bready low
      @(negedge aclk);
      bready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         aw_send(4'(k), 32'h500 + 32'(4*k), 8'd0, 3'd2, INCR);
      end
      @(negedge aclk);
      check("aw_queue_full", awready, 0);
      for (int k = 0; k < 4; k++) begin
         w_send(32'hC0 + 32'(k), 4'hF, 1'b1);
      end
      @(negedge aclk);
      check("mo_bvalid", bvalid, 1);
      check("mo_bid_head", bid, 0);
      repeat (3) @(negedge aclk);
      check("mo_bid_stable", bid, 0);
      check("mo_bresp_stable", bresp, OKAY);
      check("mo_bvalid_stable", bvalid, 1);
      check("mo_wready_b_full", wready, 0);
      bready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("mo_bvalid%0d", k), bvalid, 1);
         check($sformatf("mo_bid%0d", k), bid, k);
         @(posedge aclk);
         @(negedge aclk);
      end
      check("mo_drained", bvalid, 0);
      check("mo_mem323", dut.mem_q[323], 32'hC3);

      // One-cycle reset during beat 2 of a 4-beat burst
      aw_send(4'd9, 32'h400, 8'd3, 3'd2, INCR);
      w_send(32'hA0, 4'hF, 1'b0);
      w_send(32'hA1, 4'hF, 1'b0);
      @(negedge aclk);
      aresetn = 1'b0;
      wdata = 32'hA2; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
      @(posedge aclk);
      #1 wvalid = 1'b0;
      @(negedge aclk);
      check("mr_awready_in_reset", awready, 0);
      check("mr_wready_in_reset", wready, 0);
      check("mr_bvalid_in_reset", bvalid, 0);
      aresetn = 1'b1;
      @(negedge aclk);
      check("mr_awready_back", awready, 1);
      nb = 0;
      for (int t = 0; t < 8; t++) begin
         if (bvalid) nb++;
         @(negedge aclk);
      end
      check("mr_no_bresp", nb, 0);
      check("mr_mem256_kept", dut.mem_q[256], 32'hA0);
      check("mr_mem257_kept", dut.mem_q[257], 32'hA1);
      run_vec('{4'd10, 32'h400, 8'd1, 3'd2, INCR, 16'hFFFF, 32'hB0, 1,
                256, 32'hB0, 257, 32'hB1, OKAY}, 99);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
